pattern_eval_scheduler: RTL and testbench

//  Sequences the Hungarian-matching pattern evaluator once per video frame.

---
 rtl/pattern_pkg.sv | 17 +
 rtl/pattern_window_acc.sv | 55 +++++
 rtl/pattern_eval_scheduler.sv | 162 ++++++++++++++++
 tb/tb_pattern_eval_scheduler.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/pattern_pkg.sv
// Shared types and widths for the pattern evaluator scheduler.
package pattern_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      LAUNCH = 2'd1,
      RUN    = 2'd2,
      REPORT = 2'd3
   } state_t;

   localparam int BALL_MAX = 7;
   localparam int X_W      = 11;
   localparam int Y_W      = 10;
   localparam int ERR_W    = 15;
   localparam logic [ERR_W-1:0] ERR_SAT = 15'h7FFF;

endpackage

// File: rtl/pattern_window_acc.sv
// Aggregates per-frame error/verdict over WINDOW frames and pulses when a window closes.
module pattern_window_acc
   import pattern_pkg::*;
#(
   parameter int WINDOW = 8,
   localparam int WIN_W = $clog2(WINDOW)
) (
   input  logic                   clk_in,
   input  logic                   rst_in,
   input  logic                   update_in,
   input  logic [ERR_W-1:0]       frame_error_in,
   input  logic                   frame_correct_in,
   output logic                   window_valid_out,
   output logic [ERR_W+WIN_W-1:0] window_error_out,
   output logic [WIN_W:0]         window_correct_out
);

   logic [ERR_W+WIN_W-1:0] acc_err;
   logic [WIN_W:0]         acc_cnt;
   logic [WIN_W-1:0]       frame_cnt;
   logic [ERR_W+WIN_W-1:0] err_sum;
   logic [WIN_W:0]         cnt_sum;

   // Sums include the frame being reported so the closing frame lands in the output.
   assign err_sum = acc_err + (ERR_W+WIN_W)'(frame_error_in);
   assign cnt_sum = acc_cnt + (WIN_W+1)'(frame_correct_in);

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         acc_err            <= '0;
         acc_cnt            <= '0;
         frame_cnt          <= '0;
         window_valid_out   <= 1'b0;
         window_error_out   <= '0;
         window_correct_out <= '0;
      end else begin
         window_valid_out <= 1'b0;
         if (update_in) begin
            if (frame_cnt == WIN_W'(WINDOW - 1)) begin
               window_error_out   <= err_sum;
               window_correct_out <= cnt_sum;
               window_valid_out   <= 1'b1;
               acc_err            <= '0;
               acc_cnt            <= '0;
               frame_cnt          <= '0;
            end else begin
               acc_err   <= err_sum;
               acc_cnt   <= cnt_sum;
               frame_cnt <= frame_cnt + 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/pattern_eval_scheduler.sv
// Per-frame sequencer for the pattern evaluator: snapshot, restart, collect, aggregate.
// Optional RUN watchdog enabled by PATTERN_SCHED_TIMEOUT_EN.
//
//  state  | meaning
//  IDLE   | waiting for frame_valid_in; captures inputs on accept
//  LAUNCH | one-cycle evaluator restart strobe; stale eval_valid_in ignored
//  RUN    | waiting for evaluator result (or watchdog expiry)
//  REPORT | frame_done_out pulse; window and streak update
module pattern_eval_scheduler
   import pattern_pkg::*;
#(
   parameter int WINDOW         = 8,
   parameter int TIMEOUT_CYCLES = 4096,
   localparam int WIN_W         = $clog2(WINDOW)
) (
   input  logic                            clk_in,
   input  logic                            rst_in,
   input  logic                            frame_valid_in,
   input  logic [2:0]                      num_balls_in,
   input  logic [BALL_MAX-1:0][X_W-1:0]    model_x_in,
   input  logic [BALL_MAX-1:0][Y_W-1:0]    model_y_in,
   input  logic [BALL_MAX-1:0][X_W-1:0]    real_x_in,
   input  logic [BALL_MAX-1:0][Y_W-1:0]    real_y_in,
   output logic                            eval_rst_out,
   output logic [2:0]                      eval_num_balls_out,
   output logic [BALL_MAX-1:0][X_W-1:0]    eval_model_x_out,
   output logic [BALL_MAX-1:0][Y_W-1:0]    eval_model_y_out,
   output logic [BALL_MAX-1:0][X_W-1:0]    eval_real_x_out,
   output logic [BALL_MAX-1:0][Y_W-1:0]    eval_real_y_out,
   input  logic                            eval_valid_in,
   input  logic [ERR_W-1:0]                eval_error_in,
   input  logic                            eval_correct_in,
   output logic                            busy_out,
   output logic                            frame_done_out,
   output logic [ERR_W-1:0]                frame_error_out,
   output logic                            frame_correct_out,
   output logic                            window_valid_out,
   output logic [ERR_W+WIN_W-1:0]          window_error_out,
   output logic [WIN_W:0]                  window_correct_out,
   output logic [7:0]                      streak_out,
   output logic [7:0]                      dropped_out,
   output logic                            timeout_out
);

   state_t state, state_nxt;
   logic   accept;

   assign accept = (state == IDLE) && frame_valid_in;

`ifdef PATTERN_SCHED_TIMEOUT_EN
   localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [TMO_W-1:0] tmo_cnt;
   logic             tmo_hit;

   // Loaded in LAUNCH so terminal count is reached on the TIMEOUT_CYCLES-th RUN cycle.
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         tmo_cnt     <= '0;
         timeout_out <= 1'b0;
      end else begin
         if (state == LAUNCH)
            tmo_cnt <= TMO_W'(TIMEOUT_CYCLES - 1);
         else if (state == RUN && tmo_cnt != '0)
            tmo_cnt <= tmo_cnt - 1'b1;
         if (tmo_hit)
            timeout_out <= 1'b1;
      end
   end

   assign tmo_hit = (state == RUN) && (tmo_cnt == '0) && !eval_valid_in;
`else
   assign timeout_out = 1'b0;
`endif

   always_ff @(posedge clk_in) begin
      if (rst_in) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (frame_valid_in)
                     state_nxt = (num_balls_in == 3'd0) ? REPORT : LAUNCH;
         LAUNCH:  state_nxt = RUN;
         RUN: begin
            if (eval_valid_in)
               state_nxt = REPORT;
`ifdef PATTERN_SCHED_TIMEOUT_EN
            else if (tmo_hit)
               state_nxt = REPORT;
`endif
         end
         REPORT:  state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      busy_out       = (state != IDLE);
      eval_rst_out   = (state == LAUNCH);
      frame_done_out = (state == REPORT);
   end

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         eval_num_balls_out <= '0;
         eval_model_x_out   <= '0;
         eval_model_y_out   <= '0;
         eval_real_x_out    <= '0;
         eval_real_y_out    <= '0;
         frame_error_out    <= '0;
         frame_correct_out  <= 1'b0;
         streak_out         <= '0;
         dropped_out        <= '0;
      end else begin
         if (accept) begin
            eval_num_balls_out <= num_balls_in;
            eval_model_x_out   <= model_x_in;
            eval_model_y_out   <= model_y_in;
            eval_real_x_out    <= real_x_in;
            eval_real_y_out    <= real_y_in;
            if (num_balls_in == 3'd0) begin
               frame_error_out   <= '0;
               frame_correct_out <= 1'b0;
            end
         end
         if (frame_valid_in && state != IDLE && dropped_out != 8'hFF)
            dropped_out <= dropped_out + 1'b1;
         if (state == RUN) begin
            if (eval_valid_in) begin
               frame_error_out   <= eval_error_in;
               frame_correct_out <= eval_correct_in;
            end
`ifdef PATTERN_SCHED_TIMEOUT_EN
            else if (tmo_hit) begin
               frame_error_out   <= ERR_SAT;
               frame_correct_out <= 1'b0;
            end
`endif
         end
         if (state == REPORT) begin
            if (!frame_correct_out)
               streak_out <= '0;
            else if (streak_out != 8'hFF)
               streak_out <= streak_out + 1'b1;
         end
      end
   end

   pattern_window_acc #(.WINDOW(WINDOW)) u_window_acc (
      .clk_in             (clk_in),
      .rst_in             (rst_in),
      .update_in          (state == REPORT),
      .frame_error_in     (frame_error_out),
      .frame_correct_in   (frame_correct_out),
      .window_valid_out   (window_valid_out),
      .window_error_out   (window_error_out),
      .window_correct_out (window_correct_out)
   );

endmodule

// File: tb/tb_pattern_eval_scheduler.sv
// Directed bench for pattern_eval_scheduler with a behavioural evaluator model.
module tb_pattern_eval_scheduler;
   import pattern_pkg::*;

   localparam int WINDOW = 8;
   localparam int WIN_W  = 3;

   logic clk_in = 1'b0;
   logic rst_in = 1'b1;
   logic frame_valid_in = 1'b0;
   logic [2:0] num_balls_in = '0;
   logic [BALL_MAX-1:0][X_W-1:0] model_x_in = '0, real_x_in = '0;
   logic [BALL_MAX-1:0][Y_W-1:0] model_y_in = '0, real_y_in = '0;
   logic eval_rst_out;
   logic [2:0] eval_num_balls_out;
   logic [BALL_MAX-1:0][X_W-1:0] eval_model_x_out, eval_real_x_out;
   logic [BALL_MAX-1:0][Y_W-1:0] eval_model_y_out, eval_real_y_out;
   logic eval_valid_in = 1'b1;
   logic [ERR_W-1:0] eval_error_in = '0;
   logic eval_correct_in = 1'b0;
   logic busy_out, frame_done_out, frame_correct_out, window_valid_out, timeout_out;
   logic [ERR_W-1:0] frame_error_out;
   logic [ERR_W+WIN_W-1:0] window_error_out;
   logic [WIN_W:0] window_correct_out;
   logic [7:0] streak_out, dropped_out;

   int n_vec = 0;
   int n_bad = 0;
   int mdl_delay = 1;
   int mdl_cnt = 0;
   int win_pulses = 0;
   int done_k, rst_cnt;

   always #5 clk_in = ~clk_in;

   pattern_eval_scheduler #(.WINDOW(WINDOW), .TIMEOUT_CYCLES(16)) dut (
      .clk_in(clk_in), .rst_in(rst_in), .frame_valid_in(frame_valid_in),
      .num_balls_in(num_balls_in), .model_x_in(model_x_in), .model_y_in(model_y_in),
      .real_x_in(real_x_in), .real_y_in(real_y_in), .eval_rst_out(eval_rst_out),
      .eval_num_balls_out(eval_num_balls_out), .eval_model_x_out(eval_model_x_out),
      .eval_model_y_out(eval_model_y_out), .eval_real_x_out(eval_real_x_out),
      .eval_real_y_out(eval_real_y_out), .eval_valid_in(eval_valid_in),
      .eval_error_in(eval_error_in), .eval_correct_in(eval_correct_in),
      .busy_out(busy_out), .frame_done_out(frame_done_out),
      .frame_error_out(frame_error_out), .frame_correct_out(frame_correct_out),
      .window_valid_out(window_valid_out), .window_error_out(window_error_out),
      .window_correct_out(window_correct_out), .streak_out(streak_out),
      .dropped_out(dropped_out), .timeout_out(timeout_out)
   );

   // Evaluator model: valid rises on the mdl_delay-th cycle after restart; 0 means never.
   always @(posedge clk_in) begin
      if (eval_rst_out) begin
         eval_valid_in <= (mdl_delay == 1);
         mdl_cnt       <= 1;
      end else if (!eval_valid_in && mdl_delay != 0) begin
         if (mdl_cnt == mdl_delay - 1) eval_valid_in <= 1'b1;
         mdl_cnt <= mdl_cnt + 1;
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, got, got, exp, exp);
      end
   endtask

   task automatic set_inputs(input logic [2:0] nb, input int base);
      num_balls_in = nb;
      for (int i = 0; i < BALL_MAX; i++) begin
         model_x_in[i] = X_W'(base + i);
         real_x_in[i]  = X_W'(base + 20 + i);
         model_y_in[i] = Y_W'(base + 40 + i);
         real_y_in[i]  = Y_W'(base + 60 + i);
      end
   endtask

   // Called just after a negedge; k counts negedges after the frame_valid_in cycle.
   task automatic run_frame(input logic [2:0] nb, input int d, input int err, input logic cor,
                            input int drop_a, input int drop_b, input int drop_c);
      mdl_delay       = d;
      eval_error_in   = ERR_W'(err);
      eval_correct_in = cor;
      set_inputs(nb, 100);
      frame_valid_in  = 1'b1;
      done_k  = 0;
      rst_cnt = 0;
      for (int k = 1; k <= 200; k++) begin
         @(negedge clk_in);
         if (eval_rst_out) rst_cnt++;
         if (window_valid_out) win_pulses++;
         if (frame_done_out && done_k == 0) done_k = k;
         if (k == drop_a || k == drop_b || k == drop_c) begin
            set_inputs(3'd6, 500);
            frame_valid_in = 1'b1;
         end else begin
            frame_valid_in = 1'b0;
         end
         if (done_k != 0 && k == done_k + 1) break;
      end
      frame_valid_in = 1'b0;
      if (done_k == 0) check("frame_done_within_budget", 0, 1);
   endtask

   initial begin
      @(negedge clk_in);
      @(negedge clk_in);
      check("rst_busy", busy_out, 0);
      check("rst_eval_rst", eval_rst_out, 0);
      check("rst_frame_err", frame_error_out, 0);
      check("rst_streak", streak_out, 0);
      check("rst_dropped", dropped_out, 0);
      check("rst_snap_nb", eval_num_balls_out, 0);
      check("rst_win_err", window_error_out, 0);
      check("rst_timeout", timeout_out, 0);
      rst_in = 1'b0;
      @(negedge clk_in);

      // 3 balls, result on 5th RUN cycle, stale valid present at launch
      run_frame(3'd3, 5, 40, 1'b1, 0, 0, 0);
      check("t1_done_latency", done_k, 7);
      check("t1_eval_rst_count", rst_cnt, 1);
      check("t1_frame_err", frame_error_out, 40);
      check("t1_frame_cor", frame_correct_out, 1);
      check("t1_streak", streak_out, 1);
      check("t1_snap_nb", eval_num_balls_out, 3);
      check("t1_snap_mx2", eval_model_x_out[2], 102);
      check("t1_snap_ry1", eval_real_y_out[1], 161);
      check("t1_busy_after", busy_out, 0);

      // zero balls: no launch, report next cycle
      run_frame(3'd0, 1, 77, 1'b1, 0, 0, 0);
      check("nb0_done_latency", done_k, 1);
      check("nb0_eval_rst_count", rst_cnt, 0);
      check("nb0_frame_err", frame_error_out, 0);
      check("nb0_frame_cor", frame_correct_out, 0);
      check("nb0_streak", streak_out, 0);

      // reset while in RUN
      mdl_delay = 10;
      set_inputs(3'd2, 300);
      frame_valid_in = 1'b1;
      @(negedge clk_in); frame_valid_in = 1'b0;
      @(negedge clk_in);
      @(negedge clk_in);
      check("rstrun_busy_before", busy_out, 1);
      rst_in = 1'b1;
      @(negedge clk_in);
      rst_in = 1'b0;
      check("rstrun_busy", busy_out, 0);
      check("rstrun_snap_nb", eval_num_balls_out, 0);
      check("rstrun_snap_mx0", eval_model_x_out[0], 0);
      check("rstrun_frame_err", frame_error_out, 0);
      check("rstrun_dropped", dropped_out, 0);
      run_frame(3'd5, 2, 7, 1'b1, 0, 0, 0);
      check("rstrun_fresh_latency", done_k, 4);
      check("rstrun_fresh_err", frame_error_out, 7);
      check("rstrun_fresh_streak", streak_out, 1);

      // drops during RUN and in the REPORT cycle
      run_frame(3'd4, 5, 99, 1'b0, 3, 4, 7);
      check("drop_latency", done_k, 7);
      check("drop_count", dropped_out, 3);
      check("drop_busy_after_report", busy_out, 0);
      check("drop_snap_nb", eval_num_balls_out, 4);
      check("drop_snap_mx0", eval_model_x_out[0], 100);
      check("drop_snap_ry3", eval_real_y_out[3], 163);
      check("drop_frame_err", frame_error_out, 99);
      check("drop_streak", streak_out, 0);

      // full window: errors 10..17, odd frames correct
      rst_in = 1'b1;
      @(negedge clk_in);
      rst_in = 1'b0;
      win_pulses = 0;
      for (int i = 0; i < WINDOW; i++) begin
         run_frame(3'd2, 1, 10 + i, logic'(i % 2), 0, 0, 0);
         if (i == 0) check("win_min_latency", done_k, 3);
         if (i == WINDOW - 2) check("win_no_early_pulse", win_pulses, 0);
      end
      check("win_pulses", win_pulses, 1);
      check("win_error_sum", window_error_out, 108);
      check("win_correct_cnt", window_correct_out, 4);
      check("win_streak", streak_out, 1);

`ifdef PATTERN_SCHED_TIMEOUT_EN
      run_frame(3'd1, 0, 5, 1'b1, 0, 0, 0);
      check("tmo_latency", done_k, 18);
      check("tmo_frame_err", frame_error_out, 32'h7FFF);
      check("tmo_frame_cor", frame_correct_out, 0);
      check("tmo_flag", timeout_out, 1);
      check("tmo_busy_drops", busy_out, 0);
      run_frame(3'd1, 2, 3, 1'b1, 0, 0, 0);
      check("tmo_next_err", frame_error_out, 3);
      check("tmo_sticky", timeout_out, 1);
`else
      run_frame(3'd1, 20, 3, 1'b1, 0, 0, 0);
      check("notmo_long_wait", done_k, 22);
      check("notmo_flag", timeout_out, 0);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
